// File: rtl/mem_dport_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dport_ctrl
// MEM-stage data-port controller. Consumes the EX/MEM load/store request,
// runs the level-held request / pulsed-response handshake with the data
// cache, freezes the upstream pipeline while the access is outstanding, and
// aligns and extends returned load data for MEM/WB.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   is_load/is_store  EX/MEM holds a load / store (never both)
//   funct3            access size/sign (lb lh lw lbu lhu / sb sh sw)
//   addr              effective byte address
//   mem_byte_enable   byte-lane enables from EX/MEM
//   rs2               unshifted store data
//   hold_in           pipeline frozen elsewhere; EX/MEM will not advance
//   flush             squash the instruction currently in EX/MEM
//   data_read/write   cache request, held until data_resp
//   data_addr         word-aligned request address (registered)
//   data_mbe          request byte enables (registered)
//   data_wdata        lane-shifted store data (registered)
//   data_resp         one-cycle cache completion pulse
//   data_rdata        cache read word, valid with data_resp
//   stall_out         freeze IF..EX/MEM
//   load_valid        load_data valid for MEM/WB this cycle
//   load_data         aligned, extended load result
//   misalign_err      (only with MEM_MISALIGN_TRAP_EN) misaligned access pulse
//
// Build option: define MEM_MISALIGN_TRAP_EN to block misaligned halfword/word
// accesses and report them on misalign_err instead of issuing them.
// ---------------------------------------------------------------------------
module mem_dport_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        mem_byte_enable,
  input  logic [DATA_W-1:0] rs2,
  input  logic              hold_in,
  input  logic              flush,
  output logic              data_read,
  output logic              data_write,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_mbe,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_resp,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stall_out,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, next_state;
  logic              acc;
  logic              issue;
  logic              trap;

  // Captured request attributes needed after issue
  logic              is_load_p1;
  logic [2:0]        funct3_p1;
  logic [1:0]        ofs_p1;
  logic              squash_p1;
  logic [DATA_W-1:0] load_save_p1;
  logic [DATA_W-1:0] align_rdata;

  // Shift the addressed byte/halfword down to bit 0, then sign/zero extend.
  function automatic logic [DATA_W-1:0] align_load(
    input logic [DATA_W-1:0] rdata,
    input logic [1:0]        ofs,
    input logic [2:0]        f3
  );
    logic        [DATA_W-1:0] s;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    s = rdata >> {ofs, 3'b000};
    b = s[7:0];
    h = s[15:0];
    case (f3)
      3'b000:  align_load = {{(DATA_W-8){b[7]}}, b};
      3'b001:  align_load = {{(DATA_W-16){h[15]}}, h};
      3'b100:  align_load = {{(DATA_W-8){1'b0}}, s[7:0]};
      3'b101:  align_load = {{(DATA_W-16){1'b0}}, s[15:0]};
      default: align_load = s;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] ofs
  );
    is_misaligned = ((f3[1:0] == 2'b01) && ofs[0]) ||
                    ((f3[1:0] == 2'b10) && (ofs != 2'b00));
  endfunction

  assign trap = is_misaligned(funct3, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign acc         = (is_load | is_store) & ~flush;
  assign align_rdata = align_load(data_rdata, ofs_p1, funct3_p1);

  // Next-state and combinational outputs
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    stall_out  = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_err = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (acc && trap) begin
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_err = 1'b1;
`endif
        end else if (acc) begin
          stall_out  = 1'b1;
          issue      = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        // Releasing the stall on the response lets EX/MEM advance on that edge.
        stall_out = ~data_resp;
        if (data_resp) begin
          load_data  = align_rdata;
          load_valid = is_load_p1 & ~squash_p1 & ~flush;
          // A squashed access has no instruction left to wait on.
          if (hold_in && !squash_p1 && !flush) next_state = DONE;
          else                                 next_state = IDLE;
        end
      end
      DONE: begin
        load_data  = load_save_p1;
        load_valid = is_load_p1 & ~flush;
        if (!hold_in || flush) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request / capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      data_read    <= 1'b0;
      data_write   <= 1'b0;
      data_addr    <= '0;
      data_mbe     <= '0;
      data_wdata   <= '0;
      is_load_p1   <= 1'b0;
      funct3_p1    <= '0;
      ofs_p1       <= '0;
      squash_p1    <= 1'b0;
      load_save_p1 <= '0;
    end else begin
      state <= next_state;
      if (issue) begin
        data_read  <= is_load;
        data_write <= is_store;
        data_addr  <= {addr[ADDR_W-1:2], 2'b00};
        data_mbe   <= mem_byte_enable;
        data_wdata <= rs2 << {addr[1:0], 3'b000};
        is_load_p1 <= is_load;
        funct3_p1  <= funct3;
        ofs_p1     <= addr[1:0];
        squash_p1  <= 1'b0;
      end else if (state == BUSY) begin
        if (data_resp) begin
          data_read  <= 1'b0;
          data_write <= 1'b0;
          if (is_load_p1) load_save_p1 <= align_rdata;
        end else if (flush) begin
          // The cache cannot be cancelled; remember the squash until it answers.
          squash_p1 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_dport_ctrl.sv
module tb_mem_dport_ctrl;

  logic        clk;
  logic        rst;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [3:0]  mem_byte_enable;
  logic [31:0] rs2;
  logic        hold_in;
  logic        flush;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mbe;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        stall_out;
  logic        load_valid;
  logic [31:0] load_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks;
  int failures;
  int read_rises;
  logic prev_read;

  mem_dport_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .mem_byte_enable(mem_byte_enable),
    .rs2(rs2), .hold_in(hold_in), .flush(flush),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_mbe(data_mbe), .data_wdata(data_wdata), .data_resp(data_resp),
    .data_rdata(data_rdata), .stall_out(stall_out), .load_valid(load_valid),
    .load_data(load_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    read_rises = 0;
    prev_read  = 1'b0;
  end

  always @(posedge clk) begin
    if (data_read && !prev_read) read_rises <= read_rises + 1;
    prev_read <= data_read;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_instr();
    is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0;
    mem_byte_enable = 4'b0000; rs2 = '0; flush = 1'b0;
  endtask

  // Presents one access at posedge+1, waits for the request, answers it
  // 'lat' cycles after the request appeared, and returns what was seen.
  // Leaves the instruction driven; the caller clears it.
  task automatic run_access(
    input  bit          ld,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [3:0]  mbe,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    input  int          lat,
    output int          stall_cyc,
    output logic        ok,
    output logic        rd_obs,
    output logic        wr_obs,
    output logic [31:0] a_obs,
    output logic [3:0]  mbe_obs,
    output logic [31:0] wd_obs,
    output logic        lv_resp,
    output logic [31:0] ld_resp,
    output logic        st_resp
  );
    is_load = ld; is_store = ~ld; funct3 = f3; addr = a;
    mem_byte_enable = mbe; rs2 = wd;
    stall_cyc = 0; ok = 1'b0;
    rd_obs = 1'b0; wr_obs = 1'b0; a_obs = '0; mbe_obs = '0; wd_obs = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stall_out) stall_cyc++;
      if (data_read || data_write) begin
        ok = 1'b1;
        rd_obs = data_read; wr_obs = data_write; a_obs = data_addr;
        mbe_obs = data_mbe; wd_obs = data_wdata;
        break;
      end
      cyc();
    end
    for (int k = 1; k < lat; k++) begin
      cyc();
      @(negedge clk);
      if (stall_out) stall_cyc++;
    end
    cyc();
    data_resp = 1'b1; data_rdata = rdata;
    @(negedge clk);
    lv_resp = load_valid; ld_resp = load_data; st_resp = stall_out;
    if (stall_out) stall_cyc++;
    cyc();
    data_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_instr(); hold_in = 1'b0; data_resp = 1'b0; data_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({data_read, data_write, stall_out, load_valid} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got %b exp 0000", {data_read, data_write, stall_out, load_valid}); end
    checks++; if (data_addr !== 32'h0 || data_mbe !== 4'h0) begin failures++; $display("FAIL reset_addr got %h/%h exp 0/0", data_addr, data_mbe); end
    checks++; if (data_wdata !== 32'h0 || load_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h/%h exp 0/0", data_wdata, load_data); end
    cyc();
  endtask

  task automatic test_lw();
    int sc; logic ok, rd, wr, lv, st; logic [31:0] ao, wo, ldr; logic [3:0] mo;
    run_access(1'b1, 3'b010, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3,
               sc, ok, rd, wr, ao, mo, wo, lv, ldr, st);
    clear_instr();
    checks++; if (ok !== 1'b1 || rd !== 1'b1 || wr !== 1'b0) begin failures++; $display("FAIL lw_request got ok=%b rd=%b wr=%b exp 1 1 0", ok, rd, wr); end
    checks++; if (ao !== 32'h100) begin failures++; $display("FAIL lw_addr got %h exp 00000100", ao); end
    checks++; if (sc !== 4) begin failures++; $display("FAIL lw_stall_cycles got %0d exp 4", sc); end
    checks++; if (lv !== 1'b1 || ldr !== 32'hDEADBEEF || st !== 1'b0) begin failures++; $display("FAIL lw_result got lv=%b data=%h st=%b exp 1 deadbeef 0", lv, ldr, st); end
    @(negedge clk);
    checks++; if ({data_read, stall_out, load_valid} !== 3'b000) begin failures++; $display("FAIL lw_after got %b exp 000", {data_read, stall_out, load_valid}); end
    cyc();
  endtask

  task automatic test_load_align();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
    logic [31:0] as  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008012, 32'hFFFF8012, 32'h00000056};
    int sc; logic ok, rd, wr, lv, st; logic [31:0] ao, wo, ldr; logic [3:0] mo;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b1, f3s[i], as[i], 4'b0001, 32'h0, 32'h80123456, 1,
                 sc, ok, rd, wr, ao, mo, wo, lv, ldr, st);
      clear_instr();
      checks++; if (lv !== 1'b1 || ldr !== exp[i] || ao !== 32'h100) begin failures++; $display("FAIL align_%0d got lv=%b data=%h addr=%h exp 1 %h 00000100", i, lv, ldr, ao, exp[i]); end
      cyc();
    end
  endtask

  task automatic test_store();
    int sc; logic ok, rd, wr, lv, st; logic [31:0] ao, wo, ldr; logic [3:0] mo;
    run_access(1'b0, 3'b000, 32'h201, 4'b0010, 32'h000000AB, 32'h0, 2,
               sc, ok, rd, wr, ao, mo, wo, lv, ldr, st);
    clear_instr();
    checks++; if (ok !== 1'b1 || wr !== 1'b1 || rd !== 1'b0) begin failures++; $display("FAIL sb_request got ok=%b rd=%b wr=%b exp 1 0 1", ok, rd, wr); end
    checks++; if (ao !== 32'h200 || mo !== 4'b0010) begin failures++; $display("FAIL sb_addr_mbe got %h/%b exp 00000200/0010", ao, mo); end
    checks++; if (wo !== 32'h0000AB00) begin failures++; $display("FAIL sb_wdata got %h exp 0000ab00", wo); end
    checks++; if (lv !== 1'b0) begin failures++; $display("FAIL sb_load_valid got %b exp 0", lv); end
    @(negedge clk);
    checks++; if (data_write !== 1'b0) begin failures++; $display("FAIL sb_drop got %b exp 0", data_write); end
    cyc();
    run_access(1'b0, 3'b010, 32'h300, 4'b1111, 32'h12345678, 32'h0, 1,
               sc, ok, rd, wr, ao, mo, wo, lv, ldr, st);
    clear_instr();
    checks++; if (wo !== 32'h12345678 || sc !== 2 || lv !== 1'b0) begin failures++; $display("FAIL sw got wdata=%h stall=%0d lv=%b exp 12345678 2 0", wo, sc, lv); end
    cyc();
  endtask

  task automatic test_hold();
    int sc, r0; logic ok, rd, wr, lv, st; logic [31:0] ao, wo, ldr; logic [3:0] mo;
    r0 = read_rises;
    hold_in = 1'b1;
    run_access(1'b1, 3'b010, 32'h104, 4'b1111, 32'h0, 32'hCAFEF00D, 1,
               sc, ok, rd, wr, ao, mo, wo, lv, ldr, st);
    data_rdata = 32'h0BADF00D;
    checks++; if (lv !== 1'b1 || ldr !== 32'hCAFEF00D) begin failures++; $display("FAIL hold_resp got lv=%b data=%h exp 1 cafef00d", lv, ldr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({load_valid, stall_out, data_read} !== 3'b100 || load_data !== 32'hCAFEF00D) begin failures++; $display("FAIL hold_done_%0d got lv/st/rd=%b data=%h exp 100 cafef00d", i, {load_valid, stall_out, data_read}, load_data); end
      cyc();
    end
    hold_in = 1'b0;
    @(negedge clk);
    checks++; if (load_valid !== 1'b1 || load_data !== 32'hCAFEF00D) begin failures++; $display("FAIL hold_release got lv=%b data=%h exp 1 cafef00d", load_valid, load_data); end
    cyc();
    clear_instr();
    @(negedge clk);
    checks++; if ({load_valid, stall_out, data_read} !== 3'b000) begin failures++; $display("FAIL hold_idle got %b exp 000", {load_valid, stall_out, data_read}); end
    cyc(); cyc();
    checks++; if (read_rises - r0 !== 1) begin failures++; $display("FAIL hold_read_count got %0d exp 1", read_rises - r0); end
  endtask

  task automatic test_flush_busy();
    int lv_seen;
    lv_seen = 0;
    is_load = 1'b1; funct3 = 3'b010; addr = 32'h108; mem_byte_enable = 4'b1111;
    @(negedge clk); if (load_valid) lv_seen++;
    cyc();
    flush = 1'b1;
    @(negedge clk); if (load_valid) lv_seen++;
    checks++; if (stall_out !== 1'b1 || data_read !== 1'b1) begin failures++; $display("FAIL flush_busy_stall got st=%b rd=%b exp 1 1", stall_out, data_read); end
    cyc();
    flush = 1'b0;
    @(negedge clk); if (load_valid) lv_seen++;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL flush_busy_hold got %b exp 1", stall_out); end
    cyc();
    data_resp = 1'b1; data_rdata = 32'h11111111; hold_in = 1'b1;
    @(negedge clk); if (load_valid) lv_seen++;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL flush_busy_resp_stall got %b exp 0", stall_out); end
    cyc();
    data_resp = 1'b0; clear_instr();
    @(negedge clk); if (load_valid) lv_seen++;
    checks++; if ({stall_out, data_read} !== 2'b00) begin failures++; $display("FAIL flush_busy_drop got %b exp 00", {stall_out, data_read}); end
    checks++; if (lv_seen !== 0) begin failures++; $display("FAIL flush_busy_lv got %0d cycles exp 0", lv_seen); end
    hold_in = 1'b0;
    cyc();
  endtask

  task automatic test_flush_idle();
    int r0;
    r0 = read_rises;
    is_load = 1'b1; funct3 = 3'b010; addr = 32'h10C; mem_byte_enable = 4'b1111; flush = 1'b1;
    @(negedge clk);
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL flush_idle_stall got %b exp 0", stall_out); end
    cyc();
    clear_instr();
    @(negedge clk);
    checks++; if (data_read !== 1'b0) begin failures++; $display("FAIL flush_idle_read got %b exp 0", data_read); end
    cyc(); cyc();
    checks++; if (read_rises - r0 !== 0) begin failures++; $display("FAIL flush_idle_count got %0d exp 0", read_rises - r0); end
  endtask

  task automatic test_rst_busy();
    is_load = 1'b1; funct3 = 3'b010; addr = 32'h110; mem_byte_enable = 4'b1111;
    cyc();
    @(negedge clk);
    checks++; if (data_read !== 1'b1) begin failures++; $display("FAIL rst_busy_issue got %b exp 1", data_read); end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; clear_instr();
    @(negedge clk);
    checks++; if ({data_read, stall_out, data_addr} !== {2'b00, 32'h0}) begin failures++; $display("FAIL rst_busy got rd=%b st=%b addr=%h exp 0 0 0", data_read, stall_out, data_addr); end
    cyc();
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    int r0;
    r0 = read_rises;
    is_load = 1'b1; funct3 = 3'b010; addr = 32'h102; mem_byte_enable = 4'b1111;
    @(negedge clk);
    checks++; if (misalign_err !== 1'b1 || stall_out !== 1'b0) begin failures++; $display("FAIL misalign_pulse got err=%b st=%b exp 1 0", misalign_err, stall_out); end
    cyc();
    clear_instr();
    @(negedge clk);
    checks++; if (misalign_err !== 1'b0 || data_read !== 1'b0) begin failures++; $display("FAIL misalign_after got err=%b rd=%b exp 0 0", misalign_err, data_read); end
    cyc(); cyc();
    checks++; if (read_rises - r0 !== 0) begin failures++; $display("FAIL misalign_count got %0d exp 0", read_rises - r0); end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_lw();
    test_load_align();
    test_store();
    test_hold();
    test_flush_busy();
    test_flush_idle();
    test_rst_busy();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
